// File: rtl/serial_detect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_detect_ctrl_pkg
//  Description : Shared state encoding and width helper for the serial
//                sequence-detector controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_detect_ctrl_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Bits needed to hold a count from 0 up to and including width
    function automatic int calc_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_detect_ctrl_piso_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_shift_reg
//  Description : Parallel-in, serial-out shift register. Loads a word and
//                presents it MSB first, shifting left with zero fill.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Next-state: load has priority over shift
    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    // Shift register storage
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb_o = shreg_q[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/serial_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_detect_ctrl
//  Description : Clears a single-bit Mealy detector, feeds it a parallel word
//                MSB first, and collects the detector response word plus a
//                count of high responses, ending with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_detect_ctrl
    import serial_detect_ctrl_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = calc_cnt_w(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y_word,
    output logic [CNT_W-1:0] count_out,
    output logic             det_x,
    output logic             det_rst_n,
    input  logic             det_y
);

    state_e           state_q,  state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] y_word_q, y_word_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             busy_q;
    logic             done_q;
    logic             det_rst_n_q;

    logic             load_w;
    logic             shift_w;
    logic             msb_w;

    piso_shift_reg #(
        .WIDTH   (WIDTH)
    ) u_piso (
        .clock   (clock),
        .reset   (reset),
        .load_i  (load_w),
        .shift_i (shift_w),
        .data_i  (data_in),
        .msb_o   (msb_w)
    );

    // Next-state, capture and counter logic
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        y_word_d  = y_word_q;
        count_d   = count_q;
        load_w    = 1'b0;
        shift_w   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load_w    = 1'b1;
                    bit_cnt_d = '0;
                    y_word_d  = '0;
                    count_d   = '0;
                    state_d   = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                shift_w   = 1'b1;
                y_word_d  = {y_word_q[WIDTH-2:0], det_y};
                count_d   = count_q + CNT_W'(det_y);
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; status outputs are registered from the
    // next state so they line up with the state they describe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            y_word_q    <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            det_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            y_word_q    <= y_word_d;
            count_q     <= count_d;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= (state_d == ST_DONE);
            det_rst_n_q <= (state_d != ST_CLEAR);
        end
    end

    // Serial bit is forced low outside SHIFT so the detector never sees stale data
    assign det_x     = (state_q == ST_SHIFT) & msb_w;
    assign busy      = busy_q;
    assign done      = done_q;
    assign y_word    = y_word_q;
    assign count_out = count_q;
    assign det_rst_n = det_rst_n_q;

endmodule
`default_nettype wire
